obstacle_field: RTL and testbench

Parametrised obstacle generator for the scrolling-bar game: holds N_BARS vertical bars, each with a gap position (top of opening), an opening size and a signed vertical speed. It loads per-level bar settings through a sequential load state machine and then moves every bar once per movement tick. Movement either wraps or bounces, depending on the level, and the block flags each boundary event. It sits between the level/score controller and the VGA renderer; the renderer consumes the flattened position and opening buses.

---
 rtl/obstacle_field_if.sv | 35 +++
 rtl/obstacle_field.sv | 178 +++++++++++++++++
 tb/tb_obstacle_field.sv | 213 +++++++++++++++++++++
 3 files changed

// File: rtl/obstacle_field_if.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_field_if
// Description : Control and bar-bus bundle between the level controller,
//               the obstacle field and the renderer.
// Revision    : 1.0 - initial release
// ============================================================================
interface obstacle_field_if #(
    parameter int N_BARS = 8,
    parameter int POS_W  = 10,
    parameter int LVL_W  = 2
);
    logic                      pause;
    logic                      tick;
    logic                      level_load;
    logic [LVL_W-1:0]          level_req;
    logic [N_BARS*POS_W-1:0]   bar_pos;
    logic [N_BARS*POS_W-1:0]   bar_op;
    logic [LVL_W-1:0]          level_cur;
    logic                      level_ready;
    logic [N_BARS-1:0]         bound_evt;

    // Controller side: drives the strobes, observes the bar state.
    modport master (
        output pause, tick, level_load, level_req,
        input  bar_pos, bar_op, level_cur, level_ready, bound_evt
    );

    // Obstacle field side.
    modport slave (
        input  pause, tick, level_load, level_req,
        output bar_pos, bar_op, level_cur, level_ready, bound_evt
    );
endinterface
`default_nettype wire

// File: rtl/obstacle_field.sv
`default_nettype none
// ============================================================================
// Module      : obstacle_field
// Description : Holds N_BARS vertical bars (gap position, opening, signed
//               speed), loads per-level settings one bar per cycle and moves
//               all bars in parallel on each movement tick, wrapping or
//               bouncing at the playfield limits.
// Revision    : 1.0 - initial release
// ============================================================================
module obstacle_field #(
    parameter int N_BARS   = 8,
    parameter int POS_W    = 10,
    parameter int SCREEN_H = 480,
    parameter int N_LEVELS = 4,
    parameter int MAX_OPEN = 100,
    parameter int MIN_OPEN = 40,
    parameter int LVL_W    = (N_LEVELS > 1) ? $clog2(N_LEVELS) : 1
) (
    input  logic                clkenv,
    input  logic                rst_n,
    obstacle_field_if.slave     bus
);

    // Two guard bits so that pos+speed and 2*LIM-S never overflow.
    localparam int c_PW    = POS_W + 2;
    localparam int c_IDX_W = $clog2(N_BARS);

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_LOAD = 2'd1;
    localparam logic [1:0] c_S_RUN  = 2'd2;

    localparam logic signed [c_PW-1:0] c_SCREEN_H = c_PW'(SCREEN_H);
    localparam logic signed [c_PW-1:0] c_ONE      = c_PW'(1);

    logic [1:0]               r_state;
    logic [1:0]               w_state_nxt;
    logic [c_IDX_W-1:0]       r_idx;
    logic [LVL_W-1:0]         r_level;
    logic [LVL_W-1:0]         w_level_clamped;
    logic                     w_load_wr;
    logic                     w_load_last;
    logic                     w_move;
    logic                     w_bounce;
    logic [POS_W-1:0]         w_tbl_pos;
    logic [POS_W-1:0]         w_tbl_op;
    logic signed [c_PW-1:0]   w_tbl_spd;
    int                       w_op_i;
    int                       w_spd_i;

    // A new load always pre-empts both a running load and movement.
    assign w_load_wr   = (r_state == c_S_LOAD) && !bus.level_load;
    assign w_load_last = (r_idx == c_IDX_W'(N_BARS - 1));
    assign w_move      = (r_state == c_S_RUN) && bus.tick && !bus.pause && !bus.level_load;
    assign w_bounce    = r_level[0];

    assign bus.level_cur   = r_level;
    assign bus.level_ready = (r_state == c_S_RUN);

    // Clamp out-of-range level requests to the last level.
    always_comb begin
        w_level_clamped = bus.level_req;
        if (int'(bus.level_req) > N_LEVELS - 1) begin
            w_level_clamped = LVL_W'(N_LEVELS - 1);
        end
    end

    // Level table entry for the bar currently being loaded.
    always_comb begin
        w_op_i = MAX_OPEN - 10 * int'(r_level);
        if (w_op_i < MIN_OPEN) begin
            w_op_i = MIN_OPEN;
        end
        w_spd_i = 5 * (int'(r_level) + 1) + 5 * (int'(r_idx) % 3);
        if (r_idx[0] == 1'b0) begin
            w_spd_i = -w_spd_i;
        end
        w_tbl_op  = POS_W'(w_op_i);
        w_tbl_spd = c_PW'(w_spd_i);
        w_tbl_pos = r_idx[0] ? POS_W'(120) : POS_W'(240);
    end

    // State register, load index and captured level.
    always_ff @(posedge clkenv) begin
        if (!rst_n) begin
            r_state <= c_S_IDLE;
            r_idx   <= '0;
            r_level <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (bus.level_load) begin
                r_idx   <= '0;
                r_level <= w_level_clamped;
            end else if (w_load_wr) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

    // Next-state: a load request restarts LOAD from any state.
    always_comb begin
        w_state_nxt = r_state;
        if (bus.level_load) begin
            w_state_nxt = c_S_LOAD;
        end else begin
            case (r_state)
                c_S_IDLE: w_state_nxt = c_S_IDLE;
                c_S_LOAD: if (w_load_last) w_state_nxt = c_S_RUN;
                c_S_RUN:  w_state_nxt = c_S_RUN;
                default:  w_state_nxt = c_S_IDLE;
            endcase
        end
    end

    for (genvar gi = 0; gi < N_BARS; gi++) begin : g_bar
        logic [POS_W-1:0]       r_pos;
        logic [POS_W-1:0]       r_op;
        logic signed [c_PW-1:0] r_spd;
        logic                   r_evt;
        logic signed [c_PW-1:0] w_sum;
        logic signed [c_PW-1:0] w_lim;
        logic signed [c_PW-1:0] w_new;
        logic signed [c_PW-1:0] w_spd_nxt;
        logic                   w_hit;

        assign bus.bar_pos[gi*POS_W +: POS_W] = r_pos;
        assign bus.bar_op[gi*POS_W +: POS_W]  = r_op;
        assign bus.bound_evt[gi]              = r_evt;

        // Candidate position with a single wrap/bounce correction.
        always_comb begin
            w_sum     = $signed({2'b00, r_pos}) + r_spd;
            w_lim     = c_SCREEN_H - $signed({2'b00, r_op});
            w_new     = w_sum;
            w_spd_nxt = r_spd;
            w_hit     = 1'b0;
            if (w_sum > w_lim) begin
                w_hit = 1'b1;
                if (w_bounce) begin
                    w_new     = (w_lim <<< 1) - w_sum;
                    w_spd_nxt = -r_spd;
                end else begin
                    w_new = w_sum - (w_lim + c_ONE);
                end
            end else if (w_sum[c_PW-1]) begin
                w_hit = 1'b1;
                if (w_bounce) begin
                    w_new     = -w_sum;
                    w_spd_nxt = -r_spd;
                end else begin
                    w_new = w_sum + (w_lim + c_ONE);
                end
            end
        end

        // Per-bar state: table write during LOAD, movement during RUN.
        always_ff @(posedge clkenv) begin
            if (!rst_n) begin
                r_pos <= '0;
                r_op  <= '0;
                r_spd <= '0;
                r_evt <= 1'b0;
            end else if (w_load_wr && (r_idx == c_IDX_W'(gi))) begin
                r_pos <= w_tbl_pos;
                r_op  <= w_tbl_op;
                r_spd <= w_tbl_spd;
                r_evt <= 1'b0;
            end else if (w_move) begin
                r_pos <= w_new[POS_W-1:0];
                r_spd <= w_spd_nxt;
                r_evt <= w_hit;
            end else begin
                r_evt <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_obstacle_field.sv
`default_nettype none
// ============================================================================
// Module      : tb_obstacle_field
// Description : Self-checking bench for obstacle_field: directed vector table,
//               hand-written reset sequences and randomized traffic compared
//               every cycle against a behavioural bar model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_obstacle_field;

    localparam int NB  = 8;
    localparam int PW  = 10;
    localparam int LW  = 2;
    localparam int NL  = 4;

    logic clk;
    logic rst_n;

    obstacle_field_if #(.N_BARS(NB), .POS_W(PW), .LVL_W(LW)) bus ();

    obstacle_field #(
        .N_BARS(NB), .POS_W(PW), .SCREEN_H(480), .N_LEVELS(NL),
        .MAX_OPEN(100), .MIN_OPEN(40), .LVL_W(LW)
    ) dut (
        .clkenv (clk),
        .rst_n  (rst_n),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Behavioural model: bar state plus "bars still to load" bookkeeping.
    int m_pos [NB];
    int m_op  [NB];
    int m_spd [NB];
    int m_evt [NB];
    int m_lvl;
    int m_left;
    int m_next;
    int m_run;

    typedef struct {
        int ld; int req; int tk; int ps; int reps;
        int bar; int e_pos; int e_op; int e_evt; int e_rdy; int e_lvl;
    } vec_t;

    vec_t vt [28];

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic model_edge(input int ld, input int req, input int tk, input int ps, input int rn);
        int s, lim;
        if (rn == 0) begin
            for (int i = 0; i < NB; i++) begin
                m_pos[i] = 0; m_op[i] = 0; m_spd[i] = 0; m_evt[i] = 0;
            end
            m_lvl = 0; m_left = 0; m_next = 0; m_run = 0;
        end else if (ld != 0) begin
            m_lvl  = (req > NL - 1) ? NL - 1 : req;
            m_run  = 0; m_left = NB; m_next = 0;
            for (int i = 0; i < NB; i++) m_evt[i] = 0;
        end else if (m_left > 0) begin
            m_pos[m_next] = (m_next % 2 == 0) ? 240 : 120;
            m_op[m_next]  = (100 - 10 * m_lvl < 40) ? 40 : 100 - 10 * m_lvl;
            m_spd[m_next] = 5 * (m_lvl + 1) + 5 * (m_next % 3);
            if (m_next % 2 == 0) m_spd[m_next] = -m_spd[m_next];
            m_next++;
            m_left--;
            if (m_left == 0) m_run = 1;
            for (int i = 0; i < NB; i++) m_evt[i] = 0;
        end else if (m_run != 0 && tk != 0 && ps == 0) begin
            for (int i = 0; i < NB; i++) begin
                s = m_pos[i] + m_spd[i];
                lim = 480 - m_op[i];
                m_evt[i] = 1;
                if (s > lim) begin
                    if (m_lvl % 2 == 1) begin m_pos[i] = 2 * lim - s; m_spd[i] = -m_spd[i]; end
                    else m_pos[i] = s - (lim + 1);
                end else if (s < 0) begin
                    if (m_lvl % 2 == 1) begin m_pos[i] = -s; m_spd[i] = -m_spd[i]; end
                    else m_pos[i] = s + (lim + 1);
                end else begin
                    m_pos[i] = s;
                    m_evt[i] = 0;
                end
            end
        end else begin
            for (int i = 0; i < NB; i++) m_evt[i] = 0;
        end
    endtask

    task automatic check_model();
        logic [NB*PW-1:0] e_pos, e_op;
        logic [NB-1:0]    e_evt;
        for (int i = 0; i < NB; i++) begin
            e_pos[i*PW +: PW] = PW'(m_pos[i]);
            e_op[i*PW +: PW]  = PW'(m_op[i]);
            e_evt[i]          = (m_evt[i] != 0);
        end
        n_checks++;
        if (bus.bar_pos === e_pos && bus.bar_op === e_op && bus.bound_evt === e_evt &&
            bus.level_ready === (m_run != 0) && bus.level_cur === LW'(m_lvl)) begin
            n_pass++;
        end else begin
            $display("FAIL model_cycle t=%0t: pos=%h/%h op=%h/%h evt=%b/%b rdy=%b/%0d lvl=%0d/%0d (got/expected)",
                     $time, bus.bar_pos, e_pos, bus.bar_op, e_op, bus.bound_evt, e_evt,
                     bus.level_ready, m_run, bus.level_cur, m_lvl);
        end
    endtask

    task automatic cycle(input int ld, input int req, input int tk, input int ps);
        bus.level_load = (ld != 0);
        bus.level_req  = LW'(req);
        bus.tick       = (tk != 0);
        bus.pause      = (ps != 0);
        @(posedge clk);
        model_edge(ld, req, tk, ps, int'(rst_n));
        #1;
        check_model();
    endtask

    initial begin
        //            ld req tk ps reps bar pos  op   evt rdy lvl
        vt[0]  = '{0, 0, 1, 0, 3,  0, 0,   0,   0, 0, 0};
        vt[1]  = '{1, 0, 0, 0, 1,  0, 0,   0,   0, 0, 0};
        vt[2]  = '{0, 0, 0, 0, 7,  0, 240, 100, 0, 0, 0};
        vt[3]  = '{0, 0, 0, 0, 1,  7, 120, 100, 0, 1, 0};
        vt[4]  = '{0, 0, 0, 0, 0,  1, 120, 100, 0, 1, -1};
        vt[5]  = '{0, 0, 0, 0, 0,  2, 240, 100, 0, 1, -1};
        vt[6]  = '{0, 0, 1, 0, 48, 0, 0,   100, 0, 1, -1};
        vt[7]  = '{0, 0, 1, 0, 1,  0, 376, 100, 1, 1, -1};
        vt[8]  = '{0, 0, 0, 0, 1,  0, 376, 100, 0, 1, -1};
        vt[9]  = '{1, 0, 0, 0, 1,  0, 376, -1,  0, 0, -1};
        vt[10] = '{0, 0, 0, 0, 8,  0, 240, 100, 0, 1, 0};
        vt[11] = '{0, 0, 1, 0, 1,  1, 130, 100, 0, 1, -1};
        vt[12] = '{0, 0, 0, 0, 0,  2, 225, -1,  0, 1, -1};
        vt[13] = '{1, 1, 0, 0, 1,  1, 130, -1,  0, 0, 1};
        vt[14] = '{0, 0, 0, 0, 8,  1, 120, 90,  0, 1, 1};
        vt[15] = '{0, 0, 1, 0, 18, 1, 390, 90,  0, 1, -1};
        vt[16] = '{0, 0, 1, 0, 1,  1, 375, 90,  1, 1, -1};
        vt[17] = '{0, 0, 1, 0, 1,  1, 360, 90,  0, 1, -1};
        vt[18] = '{0, 0, 1, 1, 10, 1, 360, 90,  0, 1, -1};
        vt[19] = '{1, 2, 1, 0, 1,  1, 360, 90,  0, 0, 2};
        vt[20] = '{0, 0, 0, 0, 8,  1, 120, 80,  0, 1, 2};
        vt[21] = '{1, 3, 0, 0, 1,  0, -1,  -1,  0, 0, 3};
        vt[22] = '{0, 0, 0, 0, 8,  0, 240, 70,  0, 1, 3};
        vt[23] = '{1, 0, 0, 0, 1,  0, -1,  -1,  0, 0, 0};
        vt[24] = '{0, 0, 0, 0, 2,  0, 240, 100, 0, 0, 0};
        vt[25] = '{1, 1, 0, 0, 1,  0, 240, 100, 0, 0, 1};
        vt[26] = '{0, 0, 0, 0, 7,  0, 240, 90,  0, 0, 1};
        vt[27] = '{0, 0, 0, 0, 1,  0, 240, 90,  0, 1, 1};

        bus.level_load = 1'b0; bus.level_req = '0; bus.tick = 1'b0; bus.pause = 1'b0;

        // Reset held for two cycles: everything cleared.
        rst_n = 1'b0;
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("rst_pos",   int'(bus.bar_pos == '0), 1);
        check("rst_op",    int'(bus.bar_op == '0), 1);
        check("rst_evt",   int'(bus.bound_evt), 0);
        check("rst_ready", int'(bus.level_ready), 0);
        check("rst_lvl",   int'(bus.level_cur), 0);
        rst_n = 1'b1;

        // Directed vector table.
        for (int k = 0; k < 28; k++) begin
            for (int r = 0; r < vt[k].reps; r++) cycle(vt[k].ld, vt[k].req, vt[k].tk, vt[k].ps);
            if (vt[k].e_pos >= 0)
                check($sformatf("vec%0d_pos%0d", k, vt[k].bar), int'(bus.bar_pos[vt[k].bar*PW +: PW]), vt[k].e_pos);
            if (vt[k].e_op >= 0)
                check($sformatf("vec%0d_op%0d", k, vt[k].bar), int'(bus.bar_op[vt[k].bar*PW +: PW]), vt[k].e_op);
            check($sformatf("vec%0d_evt%0d", k, vt[k].bar), int'(bus.bound_evt[vt[k].bar]), vt[k].e_evt);
            check($sformatf("vec%0d_ready", k), int'(bus.level_ready), vt[k].e_rdy);
            if (vt[k].e_lvl >= 0)
                check($sformatf("vec%0d_lvl", k), int'(bus.level_cur), vt[k].e_lvl);
        end

        // Reset in the middle of a load, then ticks in IDLE do nothing.
        cycle(1, 2, 0, 0);
        cycle(0, 0, 0, 0);
        cycle(0, 0, 0, 0);
        rst_n = 1'b0;
        cycle(0, 0, 1, 0);
        rst_n = 1'b1;
        check("midload_rst_pos",   int'(bus.bar_pos == '0), 1);
        check("midload_rst_ready", int'(bus.level_ready), 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        check("idle_tick_pos", int'(bus.bar_pos == '0), 1);

        // Randomized traffic against the model.
        for (int n = 0; n < 1500; n++) begin
            rst_n = ($urandom_range(0, 399) != 0);
            cycle(int'($urandom_range(0, 29) == 0), int'($urandom_range(0, NL - 1)),
                  int'($urandom_range(0, 1)), int'($urandom_range(0, 4) == 0));
        end
        rst_n = 1'b1;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
